sha256_compress: RTL and testbench

SHA-256 compression engine: the consumer side of `MessageSchedule`. It steps a round index from 0 to 63, reads one schedule word W[t] per cycle, and runs the 64 compression rounds over working registers a..h. When the rounds finish, it folds the result into the running hash H0..H7, which it keeps across blocks of a multi-block message. It sits between the schedule and the Avalon-MM register file that exposes the digest to software.

---
 rtl/sha256_compress.sv | 221 ++++++++++++++++++++++
 tb/tb_sha256_compress.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_compress.sv
// ---------------------------------------------------------------------------
// sha256_compress
//
// SHA-256 compression engine. It consumes one message-schedule word per cycle
// over 64 rounds, then folds the working variables into the running hash
// H0..H7. The running hash persists across blocks, so a multi-block message
// is processed by issuing one START per block.
//
// Ports
//   CLK          in   1    system clock
//   RESET        in   1    asynchronous, active-high reset
//   START        in   1    single-cycle request to compress one block
//   FIRST_BLOCK  in   1    sampled with START; reloads H0..H7 with the IV
//   W_T          in   32   schedule word W[ROUND], used only while ROUND_ACTIVE
//   ROUND        out  6    current round index (schedule word select)
//   ROUND_ACTIVE out  1    high in cycles where W_T is consumed
//   BUSY         out  1    block in progress (LOAD, ROUND or UPDATE)
//   DONE         out  1    one-cycle pulse after H0..H7 have been updated
//   DIGEST       out  256  {H0..H7}, H0 in [255:224]
//   BLOCK_COUNT  out  32   blocks completed (only with SHA256_BLOCK_CNT_EN)
//
// Optional feature macro: SHA256_BLOCK_CNT_EN adds BLOCK_COUNT.
//
// Handshake: START is a request sampled only while the engine is idle
// (BUSY=0); a START seen while BUSY=1 is dropped, never queued. BUSY rises
// on the edge that samples START and falls on the edge that raises DONE, so
// a START presented during the DONE cycle is accepted. W_T must be valid
// combinationally in every cycle where ROUND_ACTIVE=1.
// ---------------------------------------------------------------------------
module sha256_compress (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic         FIRST_BLOCK,
  input  logic [31:0]  W_T,
  output logic [5:0]   ROUND,
  output logic         ROUND_ACTIVE,
  output logic         BUSY,
  output logic         DONE,
  output logic [255:0] DIGEST
`ifdef SHA256_BLOCK_CNT_EN
  ,
  output logic [31:0]  BLOCK_COUNT
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_ROUND  = 2'd2,
    S_UPDATE = 2'd3
  } state_e;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // K[0] sits in the most significant word.
  localparam logic [2047:0] K_TABLE = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] k_lookup(input logic [5:0] t);
    return K_TABLE[2047 - 32 * int'(t) -: 32];
  endfunction

  // Working variables: index 0..7 = a..h.
  state_e      state_q, state_d;
  logic [5:0]  round_q, round_d;
  logic        done_q, done_d;
  logic [31:0] wv_q [8];
  logic [31:0] wv_d [8];
  logic [31:0] h_q  [8];
  logic [31:0] h_d  [8];
`ifdef SHA256_BLOCK_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        first_q, first_d;
`endif

  // Round datapath, evaluated every cycle but only committed in S_ROUND.
  logic [31:0] ch, maj, t1, t2;

  always_comb begin
    ch  = (wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6]);
    maj = (wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]);
    t1  = wv_q[7] + big_sigma1(wv_q[4]) + ch + k_lookup(round_q) + W_T;
    t2  = big_sigma0(wv_q[0]) + maj;
  end

  // Next-state and register update logic.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    done_d  = 1'b0;
    wv_d    = wv_q;
    h_d     = h_q;
`ifdef SHA256_BLOCK_CNT_EN
    cnt_d   = cnt_q;
    first_d = first_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_LOAD;
          // IV is loaded on the START edge so LOAD copies it into a..h.
          if (FIRST_BLOCK) begin
            for (int i = 0; i < 8; i++) h_d[i] = IV[255 - 32 * i -: 32];
          end
`ifdef SHA256_BLOCK_CNT_EN
          first_d = FIRST_BLOCK;
`endif
        end
      end

      S_LOAD: begin
        wv_d    = h_q;
        round_d = 6'd0;
        state_d = S_ROUND;
      end

      S_ROUND: begin
        wv_d[7] = wv_q[6];
        wv_d[6] = wv_q[5];
        wv_d[5] = wv_q[4];
        wv_d[4] = wv_q[3] + t1;
        wv_d[3] = wv_q[2];
        wv_d[2] = wv_q[1];
        wv_d[1] = wv_q[0];
        wv_d[0] = t1 + t2;
        if (round_q == 6'd63) begin
          // Index returns to 0 so the schedule select never rests on 63.
          round_d = 6'd0;
          state_d = S_UPDATE;
        end else begin
          round_d = round_q + 6'd1;
        end
      end

      S_UPDATE: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + wv_q[i];
        done_d  = 1'b1;
        state_d = S_IDLE;
`ifdef SHA256_BLOCK_CNT_EN
        cnt_d = first_q ? 32'd1 : cnt_q + 32'd1;
`endif
      end

      default: begin
        state_d = S_IDLE;
        round_d = 6'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      round_q <= 6'd0;
      done_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        wv_q[i] <= 32'd0;
        h_q[i]  <= IV[255 - 32 * i -: 32];
      end
`ifdef SHA256_BLOCK_CNT_EN
      cnt_q   <= 32'd0;
      first_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      done_q  <= done_d;
      for (int i = 0; i < 8; i++) begin
        wv_q[i] <= wv_d[i];
        h_q[i]  <= h_d[i];
      end
`ifdef SHA256_BLOCK_CNT_EN
      cnt_q   <= cnt_d;
      first_q <= first_d;
`endif
    end
  end

  assign ROUND        = round_q;
  assign ROUND_ACTIVE = (state_q == S_ROUND);
  assign BUSY         = (state_q != S_IDLE);
  assign DONE         = done_q;

  for (genvar gi = 0; gi < 8; gi++) begin : g_digest
    assign DIGEST[255 - 32 * gi -: 32] = h_q[gi];
  end

`ifdef SHA256_BLOCK_CNT_EN
  assign BLOCK_COUNT = cnt_q;
`endif

endmodule

// File: tb/tb_sha256_compress.sv
// ---------------------------------------------------------------------------
// tb_sha256_compress
//
// Directed bench for sha256_compress. A local message-schedule model expands
// each 512-bit padded block into W[0..63] and serves W[ROUND] back to the
// engine combinationally. Expected digests are the published SHA-256 results.
// ---------------------------------------------------------------------------
module tb_sha256_compress;

  localparam logic [255:0] IV_DIGEST =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIGEST =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_DIGEST =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_BLK1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] TWO_BLK2  = {480'h0, 32'h000001c0};

  // ---------------- clock / reset ----------------
  logic         CLK;
  logic         RESET;
  logic         START;
  logic         FIRST_BLOCK;
  logic [31:0]  W_T;
  logic [5:0]   ROUND;
  logic         ROUND_ACTIVE;
  logic         BUSY;
  logic         DONE;
  logic [255:0] DIGEST;
`ifdef SHA256_BLOCK_CNT_EN
  logic [31:0]  BLOCK_COUNT;
`endif

  initial begin
    CLK = 1'b0;
    forever #10 CLK = ~CLK;
  end

  sha256_compress dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .START        (START),
    .FIRST_BLOCK  (FIRST_BLOCK),
    .W_T          (W_T),
    .ROUND        (ROUND),
    .ROUND_ACTIVE (ROUND_ACTIVE),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .DIGEST       (DIGEST)
`ifdef SHA256_BLOCK_CNT_EN
    ,
    .BLOCK_COUNT  (BLOCK_COUNT)
`endif
  );

  // ---------------- schedule model ----------------
  logic [31:0] sched [64];
  assign W_T = sched[ROUND];

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  task automatic load_sched(input logic [511:0] blk);
    for (int t = 0; t < 64; t++) begin
      if (t < 16) sched[t] = blk[511 - 32 * t -: 32];
      else sched[t] = ssig1(sched[t-2]) + sched[t-7] + ssig0(sched[t-15]) + sched[t-16];
    end
  endtask

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc_now = 0;
  int act_cnt = 0;
  int seq_bad = 0;

  always @(posedge CLK) cyc_now <= cyc_now + 1;

  // Round indices must step 0..63 while active and sit at 0 otherwise.
  always @(negedge CLK) begin
    if (ROUND_ACTIVE) begin
      if (int'(ROUND) != (act_cnt % 64)) seq_bad++;
      act_cnt++;
    end else if (ROUND != 6'd0) begin
      seq_bad++;
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drives START for one cycle; returns at the negedge after the sampling edge.
  task automatic start_block(input logic [511:0] blk, input logic first);
    load_sched(blk);
    act_cnt     = 0;
    FIRST_BLOCK = first;
    START       = 1'b1;
    @(negedge CLK);
    START       = 1'b0;
    FIRST_BLOCK = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (DONE !== 1'b1 && n < budget) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic wait_round(input logic [5:0] target, input int budget);
    int n;
    n = 0;
    while (ROUND !== target && n < budget) begin
      @(negedge CLK);
      n++;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [511:0] blk;
    logic         first;
    logic         check;
    logic [255:0] digest;
    logic [31:0]  cnt;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int c0;
    int d1;

    vecs[0] = '{blk: ABC_BLK,   first: 1'b1, check: 1'b1, digest: ABC_DIGEST,   cnt: 32'd1};
    vecs[1] = '{blk: EMPTY_BLK, first: 1'b1, check: 1'b1, digest: EMPTY_DIGEST, cnt: 32'd1};
    vecs[2] = '{blk: TWO_BLK1,  first: 1'b1, check: 1'b0, digest: 256'h0,       cnt: 32'd1};
    vecs[3] = '{blk: TWO_BLK2,  first: 1'b0, check: 1'b1, digest: TWO_DIGEST,   cnt: 32'd2};

    RESET       = 1'b1;
    START       = 1'b0;
    FIRST_BLOCK = 1'b0;
    load_sched(ABC_BLK);
    repeat (3) @(negedge CLK);

    // Reset state.
    chk("rst_busy",   256'(BUSY),         256'd0);
    chk("rst_done",   256'(DONE),         256'd0);
    chk("rst_round",  256'(ROUND),        256'd0);
    chk("rst_active", 256'(ROUND_ACTIVE), 256'd0);
    chk("rst_digest", DIGEST,             IV_DIGEST);
`ifdef SHA256_BLOCK_CNT_EN
    chk("rst_count",  256'(BLOCK_COUNT),  256'd0);
`endif
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // Table-driven blocks.
    for (int v = 0; v < 4; v++) begin
      start_block(vecs[v].blk, vecs[v].first);
      c0 = cyc_now;
      chk($sformatf("v%0d_busy", v), 256'(BUSY), 256'd1);
      wait_done(200);
      chk($sformatf("v%0d_latency", v), 256'(cyc_now - c0), 256'd66);
      chk($sformatf("v%0d_busy_at_done", v), 256'(BUSY), 256'd0);
      if (vecs[v].check) chk($sformatf("v%0d_digest", v), DIGEST, vecs[v].digest);
      chk($sformatf("v%0d_rounds", v), 256'(act_cnt), 256'd64);
`ifdef SHA256_BLOCK_CNT_EN
      chk($sformatf("v%0d_count", v), 256'(BLOCK_COUNT), 256'(vecs[v].cnt));
`endif
      @(negedge CLK);
      chk($sformatf("v%0d_done_pulse", v), 256'(DONE), 256'd0);
    end

    // START mid-block is dropped.
    start_block(ABC_BLK, 1'b1);
    c0 = cyc_now;
    wait_round(6'd30, 100);
    chk("r30_reached", 256'(ROUND), 256'd30);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done(200);
    chk("r30_latency", 256'(cyc_now - c0), 256'd66);
    chk("r30_digest", DIGEST, ABC_DIGEST);
    chk("r30_rounds", 256'(act_cnt), 256'd64);
    @(negedge CLK);

    // Reset mid-block abandons the block.
    start_block(EMPTY_BLK, 1'b1);
    wait_round(6'd40, 100);
    chk("r40_reached", 256'(ROUND), 256'd40);
    RESET = 1'b1;
    @(negedge CLK);
    chk("r40_busy",   256'(BUSY),         256'd0);
    chk("r40_round",  256'(ROUND),        256'd0);
    chk("r40_active", 256'(ROUND_ACTIVE), 256'd0);
    chk("r40_digest", DIGEST,             IV_DIGEST);
    RESET = 1'b0;
    @(negedge CLK);
    start_block(ABC_BLK, 1'b1);
    c0 = cyc_now;
    wait_done(200);
    chk("r40_after_latency", 256'(cyc_now - c0), 256'd66);
    chk("r40_after_digest", DIGEST, ABC_DIGEST);
`ifdef SHA256_BLOCK_CNT_EN
    chk("r40_after_count", 256'(BLOCK_COUNT), 256'd1);
`endif
    @(negedge CLK);

    // START coincident with DONE: chained blocks at a 67-cycle period.
    start_block(ABC_BLK, 1'b1);
    wait_done(200);
    d1 = cyc_now;
    chk("chain1_digest", DIGEST, ABC_DIGEST);
    start_block(ABC_BLK, 1'b1);
    chk("chain2_accepted", 256'(BUSY), 256'd1);
    wait_done(200);
    chk("chain_period", 256'(cyc_now - d1), 256'd67);
    chk("chain2_digest", DIGEST, ABC_DIGEST);
    chk("chain2_rounds", 256'(act_cnt), 256'd64);

    // Two-block message issued back to back.
    @(negedge CLK);
    start_block(TWO_BLK1, 1'b1);
    wait_done(200);
    start_block(TWO_BLK2, 1'b0);
    wait_done(200);
    chk("chain_two_digest", DIGEST, TWO_DIGEST);
`ifdef SHA256_BLOCK_CNT_EN
    chk("chain_two_count", 256'(BLOCK_COUNT), 256'd2);
`endif
    @(negedge CLK);

    chk("round_sequence", 256'(seq_bad), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
